// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: op enum, opcode/funct constants, field widths.
// Shared with the decoder, so keep values in step with it.
package instr_pkg;

    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int ADR_W   = 26;
    localparam int INSTR_W = 32;
    localparam int WADDR_W = 10;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL,
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW,
        OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_MUL_S, OP_MTC1
    } op_e;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OPC_LUI   = 6'h0F;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_COP1  = 6'h11;

    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_MULS = 6'h02;

    localparam logic [REG_W-1:0] COP1_FMT_S  = 5'h10;
    localparam logic [REG_W-1:0] COP1_MT     = 5'h04;

    function automatic logic [INSTR_W-1:0] r_word(
        input logic [OPC_W-1:0] opc, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd, input logic [REG_W-1:0] shamt, input logic [FUNCT_W-1:0] fn);
        return {opc, rs, rt, rd, shamt, fn};
    endfunction

    function automatic logic [INSTR_W-1:0] i_word(
        input logic [OPC_W-1:0] opc, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: op plus operand fields -> 32-bit instruction word.
// Float ops are packed only when FLOAT_OPS_EN is defined; otherwise reported unsupported.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [4:0]         op,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   shamt,
    input  logic [IMM_W-1:0]   imm,
    input  logic [ADR_W-1:0]   adr,
    output logic [INSTR_W-1:0] instr,
    output logic               supported
);

    localparam logic [REG_W-1:0] Z5 = '0;

    always_comb begin
        instr     = '0;
        supported = 1'b1;
        case (op_e'(op))
            OP_ADD:   instr = r_word(OPC_RTYPE, rs, rt, rd, Z5, FN_ADD);
            OP_ADDU:  instr = r_word(OPC_RTYPE, rs, rt, rd, Z5, FN_ADDU);
            OP_SUB:   instr = r_word(OPC_RTYPE, rs, rt, rd, Z5, FN_SUB);
            OP_AND:   instr = r_word(OPC_RTYPE, rs, rt, rd, Z5, FN_AND);
            OP_OR:    instr = r_word(OPC_RTYPE, rs, rt, rd, Z5, FN_OR);
            OP_SLL:   instr = r_word(OPC_RTYPE, Z5, rt, rd, shamt, FN_SLL);
            OP_SRL:   instr = r_word(OPC_RTYPE, Z5, rt, rd, shamt, FN_SRL);
            OP_ADDI:  instr = i_word(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: instr = i_word(OPC_ADDIU, rs, rt, imm);
            OP_ANDI:  instr = i_word(OPC_ANDI, rs, rt, imm);
            OP_ORI:   instr = i_word(OPC_ORI, rs, rt, imm);
            OP_LUI:   instr = i_word(OPC_LUI, Z5, rt, imm);
            OP_LW:    instr = i_word(OPC_LW, rs, rt, imm);
            OP_SW:    instr = i_word(OPC_SW, rs, rt, imm);
            OP_BEQ:   instr = i_word(OPC_BEQ, rs, rt, imm);
            OP_BNE:   instr = i_word(OPC_BNE, rs, rt, imm);
            OP_J:     instr = {OPC_J, adr};
            OP_JAL:   instr = {OPC_JAL, adr};
`ifdef FLOAT_OPS_EN
            OP_MUL_S: instr = r_word(OPC_COP1, COP1_FMT_S, rt, rd, shamt, FN_MULS);
            OP_MTC1:  instr = {OPC_COP1, COP1_MT, rt, rd, 11'h000};
`endif
            default:  supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encode.sv
// One-entry output register around instr_field_pack, with word-address counter
// and sticky error / saturating reject count. FLOAT_OPS_EN enables MUL_S and MTC1.
module instruction_encode
    import instr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         op,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic [4:0]         rd,
    input  logic [4:0]         shamt,
    input  logic [15:0]        imm,
    input  logic [25:0]        adr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instr,
    output logic [9:0]         wr_addr,
    output logic               err,
    output logic [7:0]         err_cnt
);

    logic [INSTR_W-1:0] packed_word;
    logic               packed_ok;

    instr_field_pack u_pack (
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .adr       (adr),
        .instr     (packed_word),
        .supported (packed_ok)
    );

    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               in_fire, out_fire;

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
            wr_addr_d   = wr_addr_q + 1'b1;
        end
        // A new word lands in the same edge the old one leaves, so no bubble.
        if (in_fire) begin
            if (packed_ok) begin
                out_valid_d = 1'b1;
                instr_d     = packed_word;
            end else begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            wr_addr_q   <= wr_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign wr_addr   = wr_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instruction_encode.sv
// Directed, table-driven bench for instruction_encode; float expectations follow FLOAT_OPS_EN.
module tb_instruction_encode;

`ifdef FLOAT_OPS_EN
    localparam bit FLOAT = 1'b1;
`else
    localparam bit FLOAT = 1'b0;
`endif

    localparam logic [4:0] ADD = 5'd0, ADDU = 5'd1, SUB = 5'd2, AND_ = 5'd3, SLL = 5'd5,
                           SRL = 5'd6, ADDI = 5'd7, ORI = 5'd10, LUI = 5'd11, LW = 5'd12,
                           SW = 5'd13, BNE = 5'd15, J = 5'd16, JAL = 5'd17, MULS = 5'd18,
                           MTC1 = 5'd19;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  op, rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] adr;
    logic [31:0] instr;
    logic [9:0]  wr_addr;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_encode dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .adr       (adr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .wr_addr   (wr_addr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        string       name;
        logic [4:0]  op, rs, rt, rd, shamt;
        logic [15:0] imm;
        logic [25:0] adr;
        logic [31:0] exp;
        bit          sup;
        bit          flt;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                         input logic [25:0] a);
        in_valid = 1'b1; op = o; rs = s; rt = t; rd = d; shamt = sh; imm = im; adr = a;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] o, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                input logic [15:0] im, input logic [25:0] a,
                                input logic [31:0] e, input bit sp, input bit fl);
        vec_t v;
        v.name = n; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.shamt = sh;
        v.imm = im; v.adr = a; v.exp = e; v.sup = sp; v.flt = fl;
        return v;
    endfunction

    initial begin
        int   exp_addr;
        int   exp_cnt;
        bit   ok;
        logic [31:0] held;

        vecs.push_back(mk("ADD",   ADD,  5'd1,  5'd2,  5'd3, 5'd0,  16'h0,    26'h0,       32'h00221820, 1, 0));
        vecs.push_back(mk("SUB",   SUB,  5'd4,  5'd5,  5'd6, 5'd7,  16'h0,    26'h0,       32'h00853022, 1, 0));
        vecs.push_back(mk("SLL",   SLL,  5'd9,  5'd2,  5'd3, 5'd4,  16'h0,    26'h0,       32'h00021900, 1, 0));
        vecs.push_back(mk("SRL",   SRL,  5'd0,  5'd1,  5'd1, 5'd31, 16'h0,    26'h0,       32'h00010FC2, 1, 0));
        vecs.push_back(mk("ADDU",  ADDU, 5'd0,  5'd0,  5'd0, 5'd3,  16'h0,    26'h0,       32'h00000021, 1, 0));
        vecs.push_back(mk("AND",   AND_, 5'd1,  5'd2,  5'd3, 5'd0,  16'h0,    26'h0,       32'h00221824, 1, 0));
        vecs.push_back(mk("LUI",   LUI,  5'd7,  5'd1,  5'd0, 5'd0,  16'hABCD, 26'h0,       32'h3C01ABCD, 1, 0));
        vecs.push_back(mk("SW",    SW,   5'd29, 5'd31, 5'd0, 5'd0,  16'hFFFC, 26'h0,       32'hAFBFFFFC, 1, 0));
        vecs.push_back(mk("BNE",   BNE,  5'd1,  5'd2,  5'd0, 5'd0,  16'hFFFF, 26'h0,       32'h1422FFFF, 1, 0));
        vecs.push_back(mk("ORI",   ORI,  5'd3,  5'd4,  5'd0, 5'd0,  16'h1234, 26'h0,       32'h34641234, 1, 0));
        vecs.push_back(mk("JAL",   JAL,  5'd0,  5'd0,  5'd0, 5'd0,  16'h0,    26'h3FFFFFF, 32'h0FFFFFFF, 1, 0));
        vecs.push_back(mk("BADOP", 5'd25,5'd1,  5'd1,  5'd1, 5'd1,  16'h1,    26'h1,       32'h0,        0, 0));
        vecs.push_back(mk("MTC1",  MTC1, 5'd0,  5'd4,  5'd2, 5'd0,  16'h0,    26'h0,       32'h44841000, 1, 1));
        vecs.push_back(mk("MUL_S", MULS, 5'd0,  5'd1,  5'd2, 5'd3,  16'h0,    26'h0,       32'h460110C2, 1, 1));

        in_valid = 0; out_ready = 1; op = 0; rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; adr = 0;
        rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Table: one bundle per vector, consumed the following cycle.
        exp_addr = 0; exp_cnt = 0;
        foreach (vecs[i]) begin
            ok = vecs[i].sup && (!vecs[i].flt || FLOAT);
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt, vecs[i].imm, vecs[i].adr);
            out_ready = 1'b1;
            check({vecs[i].name, "_in_ready"}, in_ready, 1);
            tick();
            in_valid = 1'b0;
            if (!ok) exp_cnt++;
            check({vecs[i].name, "_out_valid"}, out_valid, ok);
            if (ok) begin
                check({vecs[i].name, "_instr"}, instr, vecs[i].exp);
            end
            check({vecs[i].name, "_wr_addr"}, wr_addr, exp_addr);
            check({vecs[i].name, "_err"}, err, exp_cnt != 0);
            check({vecs[i].name, "_err_cnt"}, err_cnt, exp_cnt);
            $display("vec %0s: instr=%08h addr=%0d valid=%0b err_cnt=%0d", vecs[i].name, instr, wr_addr, out_valid, err_cnt);
            tick();
            if (ok) exp_addr++;
        end

        // Back-to-back ADDI then J with no bubble.
        do_reset();
        drive(ADDI, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0010, 26'h0);
        tick();
        check("b2b_addi_instr", instr, 32'h20050010);
        check("b2b_addi_addr", wr_addr, 0);
        check("b2b_addi_valid", out_valid, 1);
        drive(J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
        check("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b_j_instr", instr, 32'h08000100);
        check("b2b_j_addr", wr_addr, 1);
        check("b2b_j_valid", out_valid, 1);
        $display("b2b: J instr=%08h addr=%0d", instr, wr_addr);
        tick();
        check("b2b_drain_valid", out_valid, 0);
        check("b2b_drain_addr", wr_addr, 2);

        // LW held under backpressure; a competing bundle must not be taken.
        do_reset();
        drive(LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        tick();
        out_ready = 1'b0;
        drive(ADD, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_instr", instr, 32'h8FA80004);
            check("hold_valid", out_valid, 1);
            check("hold_addr", wr_addr, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("hold_release_ready", in_ready, 1);
        tick();
        check("hold_done_valid", out_valid, 0);
        check("hold_done_addr", wr_addr, 1);
        $display("hold: LW single handshake, addr now %0d", wr_addr);

        // Address wrap: stream 1025 ADD words.
        do_reset();
        drive(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        for (int k = 1; k <= 1025; k++) begin
            tick();
            if (k == 1024) check("wrap_addr_1023", wr_addr, 1023);
            if (k == 1025) begin
                check("wrap_addr_0", wr_addr, 0);
                check("wrap_valid", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        $display("wrap: word 1025 written at addr 0");

        // Saturating reject counter.
        do_reset();
        drive(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int k = 0; k < 260; k++) tick();
        in_valid = 1'b0;
        check("sat_err_cnt", err_cnt, 8'd255);
        check("sat_no_word", out_valid, 0);
        check("sat_addr", wr_addr, 0);
        $display("sat: err_cnt=%0d after 260 rejects", err_cnt);

        // Reset while a word is held, with err set and address advanced.
        drive(ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        held = instr;
        check("prerst_valid", out_valid, 1);
        check("prerst_addr", wr_addr, 1);
        rst = 1'b1;
        #1;
        check("rst_hold_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        check("rst_held_valid", out_valid, 0);
        check("rst_held_addr", wr_addr, 0);
        check("rst_held_err", err, 0);
        check("rst_held_err_cnt", err_cnt, 0);
        check("rst_held_instr", instr, 0);
        $display("rst: held word %08h discarded", held);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encode.md
INSTRUCTION_ENCODE -- requirements
Module: instruction_encode

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  operand bundle present.
REQ-005 in_ready  out  1  block accepts the bundle this cycle.
REQ-006 op  in  5  operation code from the shared package enum: ADD, ADDU, SUB, AND, OR, SLL, SRL, ADDI, ADDIU, ANDI, ORI, LUI, LW, SW, BEQ, BNE, J, JAL, MUL_S, MTC1.
REQ-007 rs, rt, rd, shamt  in  5 each  register and shift fields.
REQ-008 imm  in  16  I-type immediate; adr  in  26  J-type target.
REQ-009 out_valid  out  1  instr/wr_addr hold a valid word.
REQ-010 out_ready  in  1  consumer (instruction-memory writer) takes the word.
REQ-011 instr  out  32  encoded instruction word.
REQ-012 wr_addr  out  10  word address for instr; wraps.
REQ-013 err  out  1  sticky: an unsupported op was presented.
REQ-014 err_cnt  out  8  count of rejected bundles, saturating at 255.

Function
REQ-015 The block SHALL be a one-entry output register; in_ready = !out_valid || out_ready.
REQ-016 Input handshake (in_valid && in_ready) with a supported op SHALL load instr on the next edge with out_valid=1; latency exactly 1 cycle.
REQ-017 With out_valid=1 and out_ready=0, instr, wr_addr and out_valid SHALL hold stable.
REQ-018 Simultaneous output handshake and new input SHALL replace the word in the same edge without a bubble.
REQ-019 wr_addr SHALL increment by 1 after each output handshake, wrapping 1023 to 0.
REQ-020 R-type: {6'h00, rs, rt, rd, shamt, funct}; funct ADD 20h, ADDU 21h, SUB 22h, AND 24h, OR 25h, SLL 00h, SRL 02h; shamt forced 0 except SLL/SRL; rs forced 0 for SLL/SRL.
REQ-021 I-type: {opcode, rs, rt, imm}; ADDI 08h, ADDIU 09h, ANDI 0Ch, ORI 0Dh, LUI 0Fh (rs forced 0), LW 23h, SW 2Bh, BEQ 04h, BNE 05h.
REQ-022 J-type: {opcode, adr}; J 02h, JAL 03h.
REQ-023 MUL_S: {6'h11, 5'h10, rt, rd, shamt, 6'h02}; MTC1: {6'h11, 5'h04, rt, rd, 11'h000}.
REQ-024 Unsupported op with in_valid && in_ready SHALL be consumed, SHALL NOT produce a word or advance wr_addr, SHALL set err and increment err_cnt.
REQ-025 A rejected op SHALL NOT disturb a word already held in the output register.

Reset
REQ-026 rst SHALL force out_valid=0, instr=0, wr_addr=0, err=0, err_cnt=0 on the next edge, discarding any held word.
REQ-027 During rst high, in_ready SHALL be 0.

Configuration
REQ-028 Macro FLOAT_OPS_EN defined: MUL_S and MTC1 encoded per REQ-023.
REQ-029 FLOAT_OPS_EN undefined: MUL_S and MTC1 SHALL be treated as unsupported per REQ-024.

Structure
REQ-030 Op enum, opcode and funct constants, and field widths SHALL live in shared package instr_pkg, also used by the decoder.
REQ-031 Field packing SHALL be a combinational sub-module instr_field_pack; the handshake, counters and error state stay in instruction_encode.

Verification
REQ-032 ADD rs=1 rt=2 rd=3, out_ready=1 -> instr=00221820h, wr_addr=0, out_valid one cycle later.
REQ-033 ADDI rs=0 rt=5 imm=0010h then J adr=100h back-to-back -> 20050010h at addr 0, 08000100h at addr 1, no bubble.
REQ-034 LW rt=8 rs=29 imm=4 with out_ready=0 for 3 cycles -> 8FA80004h held stable, in_ready=0, then a single handshake.
REQ-035 MTC1 rt=4 rd=2 -> 44841000h with FLOAT_OPS_EN; without it -> no word, err=1, err_cnt=1.
REQ-036 1024 ADD words -> wr_addr wraps to 0 on word 1025.
REQ-037 rst asserted while a word is held -> out_valid=0, wr_addr=0, err=0 next cycle.
